// File: rtl/trace_event_player_if.sv
// rtl/trace_event_player_if.sv - table load port and monitor event stream of the trace event player
interface trace_event_player_if #(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int DELTA_W    = 32,
    parameter int ADDR_W     = 4
);
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic [DELTA_W-1:0]           wr_delta;
    logic [NUM_INPUTS-1:0]        wr_mask;
    logic [NUM_INPUTS*DATA_W-1:0] wr_data;
    logic                         ready;
    logic [NUM_INPUTS*DATA_W-1:0] input_flat;
    logic [NUM_INPUTS-1:0]        new_input;

    modport master (
        output wr_en, wr_addr, wr_delta, wr_mask, wr_data, ready,
        input  input_flat, new_input
    );

    modport slave (
        input  wr_en, wr_addr, wr_delta, wr_mask, wr_data, ready,
        output input_flat, new_input
    );
endinterface

// File: rtl/trace_event_player.sv
// rtl/trace_event_player.sv - replays a preloaded table of timed multi-channel events into a monitor
module trace_event_player #(
    parameter int NUM_INPUTS = 1,
    parameter int DATA_W     = 64,
    parameter int DELTA_W    = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [ADDR_W:0]      num_events_i,
    input  logic                 loop_mode_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    trace_event_player_if.slave  bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ADDR_W-1:0]    event_idx_o,
    output logic [15:0]          loop_cnt_o,
    output logic [31:0]          stall_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_N   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   N_ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_FIRST = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    logic [DELTA_W-1:0]           delta_mem [DEPTH];
    logic [NUM_INPUTS-1:0]        mask_mem  [DEPTH];
    logic [NUM_INPUTS*DATA_W-1:0] data_mem  [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DELTA_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic [15:0]         loop_cnt_q, loop_cnt_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    logic                         tbl_we;
    logic [DELTA_W-1:0]           cur_delta;
    logic [NUM_INPUTS-1:0]        cur_mask;
    logic [NUM_INPUTS*DATA_W-1:0] cur_data;
    logic [ADDR_W:0]              n_start;
    logic                         is_last;
    logic                         fire_ok;
    logic                         arm;
    logic [DELTA_W-1:0]           arm_delta;

    // The table is only writable while no playback is reading it.
    assign tbl_we = en_i && bus.wr_en && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            delta_mem[bus.wr_addr] <= bus.wr_delta;
            mask_mem[bus.wr_addr]  <= bus.wr_mask;
            data_mem[bus.wr_addr]  <= bus.wr_data;
        end
    end

    assign cur_delta = delta_mem[idx_q];
    assign cur_mask  = mask_mem[idx_q];
    assign cur_data  = data_mem[idx_q];
    assign n_start   = (num_events_i > DEPTH_N) ? DEPTH_N : num_events_i;
    assign is_last   = ({1'b0, idx_q} == (n_q - N_ONE));

    // A mask-0 entry is a pure delay and never waits on the monitor.
    assign fire_ok = en_i && !stop_i && (state_q == S_FIRE) &&
                     ((cur_mask == '0) || bus.ready);

    always_comb begin
        bus.new_input  = '0;
        bus.input_flat = '0;
        if (fire_ok) begin
            bus.new_input = cur_mask;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (cur_mask[k]) begin
                    bus.input_flat[k*DATA_W +: DATA_W] = cur_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        loop_d      = loop_q;
        done_d      = done_q;
        loop_cnt_d  = loop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        arm         = 1'b0;
        arm_delta   = cur_delta;

        if (stop_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        n_d         = n_start;
                        loop_d      = loop_mode_i;
                        idx_d       = IDX_FIRST;
                        stall_cnt_d = '0;
                        loop_cnt_d  = '0;
                        done_d      = 1'b0;
                        if (n_start == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            arm       = 1'b1;
                            arm_delta = delta_mem[IDX_FIRST];
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q - DELTA_W'(1);
                    end
                end
                S_FIRE: begin
                    if (fire_ok) begin
                        if (is_last) begin
                            if (loop_q) begin
                                idx_d     = IDX_FIRST;
                                arm       = 1'b1;
                                arm_delta = delta_mem[IDX_FIRST];
                                if (loop_cnt_q != '1) begin
                                    loop_cnt_d = loop_cnt_q + 16'd1;
                                end
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d     = idx_q + IDX_ONE;
                            arm       = 1'b1;
                            arm_delta = delta_mem[idx_q + IDX_ONE];
                        end
                    end else if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Delay d means d WAIT cycles, so d=0 goes straight to FIRE for back-to-back events.
        if (arm) begin
            if (arm_delta == '0) begin
                state_d = S_FIRE;
                cnt_d   = '0;
            end else begin
                state_d = S_WAIT;
                cnt_d   = arm_delta - DELTA_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            loop_q      <= 1'b0;
            done_q      <= 1'b0;
            loop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (en_i) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            loop_q      <= loop_d;
            done_q      <= done_d;
            loop_cnt_q  <= loop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_o      = (state_q == S_WAIT) || (state_q == S_FIRE);
    assign done_o      = done_q;
    assign event_idx_o = idx_q;
    assign loop_cnt_o  = loop_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_trace_event_player.sv
// tb/tb_trace_event_player.sv - self-checking bench for trace_event_player
module tb_trace_event_player;
    localparam int NI    = 2;
    localparam int DW    = 16;
    localparam int DLW   = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst, en, start, stop, loop_mode;
    logic [AW:0]   num_events;
    logic          busy, done;
    logic [AW-1:0] event_idx;
    logic [15:0]   loop_cnt;
    logic [31:0]   stall_cnt;

    trace_event_player_if #(.NUM_INPUTS(NI), .DATA_W(DW), .DELTA_W(DLW), .ADDR_W(AW)) bus ();

    trace_event_player #(.NUM_INPUTS(NI), .DATA_W(DW), .DELTA_W(DLW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_i(en), .num_events_i(num_events), .loop_mode_i(loop_mode),
        .start_i(start), .stop_i(stop), .bus(bus), .busy_o(busy), .done_o(done),
        .event_idx_o(event_idx), .loop_cnt_o(loop_cnt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [DLW-1:0]   m_delta [DEPTH];
    logic [NI-1:0]    m_mask  [DEPTH];
    logic [NI*DW-1:0] m_data  [DEPTH];

    int               strobes[$];
    logic [NI*DW-1:0] strobe_flat[$];
    int               done_at;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NI*DW-1:0] masked(input logic [NI-1:0] m, input logic [NI*DW-1:0] v);
        logic [NI*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NI; k++) if (m[k]) r[k*DW +: DW] = v[k*DW +: DW];
        return r;
    endfunction

    task automatic write_entry(input int a, input int d, input logic [NI-1:0] m, input logic [NI*DW-1:0] v);
        bus.wr_en    = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_delta = DLW'(d);
        bus.wr_mask  = m;
        bus.wr_data  = v;
        tick();
        bus.wr_en    = 1'b0;
        m_delta[a]   = DLW'(d);
        m_mask[a]    = m;
        m_data[a]    = v;
    endtask

    // Timing model: an event falls due delta enabled cycles after the previous consumption;
    // once due it waits for ready (unless its mask is empty).
    task automatic play(input int n_ev, input bit lp, input int cycles, input int rdy_pct,
                        input int rdy_lo, input int rdy_hi, input int stop_at,
                        input int en_lo, input int en_hi, input bit wr_busy);
        int nn, k, due, t, st, lc;
        bit act, dn, cons;
        logic [NI-1:0]    m, exp_ni;
        logic [NI*DW-1:0] exp_flat;
        strobes.delete();
        strobe_flat.delete();
        done_at = -1;
        nn = (n_ev > DEPTH) ? DEPTH : n_ev;
        k = 0; due = 0; t = 0; st = 0; lc = 0; act = 0; dn = 0;
        for (int c = 0; c <= cycles; c++) begin
            if (c > 0) tick();
            start      = (c == 0);
            stop       = (c == stop_at);
            en         = !(c >= en_lo && c < en_hi);
            num_events = (AW+1)'(n_ev);
            loop_mode  = lp;
            bus.ready  = (c >= rdy_lo && c < rdy_hi) ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
            bus.wr_en  = wr_busy && (c == 2);
            bus.wr_addr = '0;
            bus.wr_delta = DLW'($urandom_range(255));
            bus.wr_mask = NI'($urandom_range(3));
            bus.wr_data = NI*DW'($urandom);
            @(negedge clk);
            exp_ni = '0; exp_flat = '0; cons = 0;
            if (c > 0) begin
                total++;
                if ({busy, done, event_idx, loop_cnt, stall_cnt} !== {act, dn, AW'(k), 16'(lc), 32'(st)}) begin
                    $display("FAIL status c=%0d busy/done/idx/loops/stalls got %b %b %0d %0d %0d want %b %b %0d %0d %0d",
                             c, busy, done, event_idx, loop_cnt, stall_cnt, act, dn, k, lc, st);
                end else passed++;
                if (en) t++;
                if (en && stop) begin
                    act = 0;
                    dn  = 0;
                end else if (en && act && t >= due) begin
                    m = m_mask[k];
                    if (m == '0) cons = 1;
                    else if (bus.ready) begin
                        cons = 1;
                        exp_ni = m;
                        exp_flat = masked(m, m_data[k]);
                    end else st++;
                end
            end
            total++;
            if (bus.new_input !== exp_ni || bus.input_flat !== exp_flat) begin
                $display("FAIL strobe c=%0d new_input=%b input_flat=%h want %b %h",
                         c, bus.new_input, bus.input_flat, exp_ni, exp_flat);
            end else passed++;
            if (bus.new_input != '0) begin
                strobes.push_back(c);
                strobe_flat.push_back(bus.input_flat);
            end
            if (done && done_at < 0) done_at = c;
            if (c == 0) begin
                if (nn == 0) dn = 1;
                else begin
                    act = 1;
                    due = 1 + int'(m_delta[0]);
                end
            end else if (cons) begin
                if (k == nn - 1) begin
                    if (lp) begin
                        k = 0; lc++;
                        due = t + 1 + int'(m_delta[0]);
                    end else begin
                        act = 0; dn = 1;
                    end
                end else begin
                    k++;
                    due = t + 1 + int'(m_delta[k]);
                end
            end
        end
        tick();
        start = 0; en = 1; bus.ready = 0; bus.wr_en = 0;
        @(negedge clk);
        tick();
    endtask

    task automatic end_play();
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        @(negedge clk);
        total++; if (bus.new_input !== '0) $display("FAIL reset_new_input got %b want 0", bus.new_input); else passed++;
        total++; if (bus.input_flat !== '0) $display("FAIL reset_input_flat got %h want 0", bus.input_flat); else passed++;
        total++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {busy, done}); else passed++;
        total++; if (event_idx !== '0) $display("FAIL reset_event_idx got %0d want 0", event_idx); else passed++;
        total++; if (loop_cnt !== '0 || stall_cnt !== '0) $display("FAIL reset_counters got %0d %0d want 0 0", loop_cnt, stall_cnt); else passed++;
        tick();
    endtask

    task automatic test_basic_timing();
        write_entry(0, 3, 2'b01, 32'd1);
        write_entry(1, 0, 2'b01, 32'd2);
        write_entry(2, 1, 2'b01, 32'd3);
        play(3, 0, 12, 100, -1, -1, -1, -1, -1, 0);
        total++;
        if (strobes.size() != 3 || strobes[0] != 4 || strobes[1] != 5 || strobes[2] != 7)
            $display("FAIL basic_strobe_cycles got %p want '{4,5,7}", strobes);
        else passed++;
        total++; if (done_at != 8) $display("FAIL basic_done_cycle got %0d want 8", done_at); else passed++;
        end_play();
    endtask

    task automatic test_multi_channel();
        write_entry(0, 1, 2'b11, {16'hFFFB, 16'd7});
        write_entry(1, 0, 2'b01, {16'd4, 16'd9});
        play(2, 0, 6, 100, -1, -1, -1, -1, -1, 0);
        total++;
        if (strobe_flat.size() != 2 || strobe_flat[0] !== {16'hFFFB, 16'd7} || strobe_flat[1] !== 32'h0000_0009)
            $display("FAIL multi_channel_values got %p want '{fffb0007,00000009}", strobe_flat);
        else passed++;
        end_play();
    endtask

    task automatic test_backpressure();
        write_entry(0, 2, 2'b01, 32'd11);
        write_entry(1, 1, 2'b10, 32'h0022_0000);
        play(2, 0, 12, 100, 3, 7, -1, -1, -1, 0);
        total++;
        if (strobes.size() != 2 || strobes[0] != 7 || strobes[1] != 9)
            $display("FAIL backpressure_cycles got %p want '{7,9}", strobes);
        else passed++;
        total++; if (stall_cnt !== 32'd4) $display("FAIL backpressure_stalls got %0d want 4", stall_cnt); else passed++;
        end_play();
    endtask

    task automatic test_loop_and_stop();
        write_entry(0, 0, 2'b01, 32'd5);
        write_entry(1, 0, 2'b10, 32'h0006_0000);
        play(2, 1, 10, 100, -1, -1, 7, -1, -1, 1);
        total++; if (strobes.size() != 6) $display("FAIL loop_strobe_count got %0d want 6", strobes.size()); else passed++;
        total++; if (loop_cnt !== 16'd3 || done !== 1'b0) $display("FAIL loop_count_done got %0d %b want 3 0", loop_cnt, done); else passed++;
        end_play();
        write_entry(1, 5, 2'b10, 32'h0006_0000);
        play(2, 1, 10, 100, -1, -1, 4, -1, -1, 0);
        total++; if (strobes.size() != 1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL stop_in_wait got strobes=%0d busy=%b done=%b want 1 0 0", strobes.size(), busy, done);
        else passed++;
        end_play();
    endtask

    task automatic test_count_limits();
        play(0, 0, 4, 100, -1, -1, -1, -1, -1, 0);
        total++; if (done_at != 1 || strobes.size() != 0) $display("FAIL zero_events got done_at=%0d strobes=%0d want 1 0", done_at, strobes.size()); else passed++;
        end_play();
        for (int a = 0; a < DEPTH; a++) write_entry(a, 0, 2'b01, 32'(a + 1));
        play(DEPTH + 5, 0, DEPTH + 6, 100, -1, -1, -1, -1, -1, 0);
        total++; if (strobes.size() != DEPTH) $display("FAIL overflow_count got %0d want %0d", strobes.size(), DEPTH); else passed++;
        end_play();
    endtask

    task automatic test_enable();
        write_entry(0, 4, 2'b10, 32'h0033_0000);
        play(1, 0, 12, 100, -1, -1, -1, 2, 5, 0);
        total++; if (strobes.size() != 1 || strobes[0] != 8) $display("FAIL enable_in_wait got %p want '{8}", strobes); else passed++;
        end_play();
        write_entry(0, 1, 2'b01, 32'd44);
        play(1, 0, 10, 100, -1, -1, -1, 2, 5, 0);
        total++; if (strobes.size() != 1 || strobes[0] != 5) $display("FAIL enable_in_fire got %p want '{5}", strobes); else passed++;
        end_play();
    endtask

    task automatic test_reset_mid_fire();
        write_entry(0, 0, 2'b11, 32'h1234_5678);
        num_events = 1; loop_mode = 0; bus.ready = 0; start = 1;
        tick();
        start = 0;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_fire_busy got %b want 1", busy); else passed++;
        tick();
        rst = 1;
        tick();
        rst = 0; bus.ready = 1;
        @(negedge clk);
        total++; if (bus.new_input !== '0 || bus.input_flat !== '0) $display("FAIL reset_fire_outputs got %b %h want 0 0", bus.new_input, bus.input_flat); else passed++;
        total++; if ({busy, done, stall_cnt} !== 34'd0) $display("FAIL reset_fire_state got %b %b %0d want 0 0 0", busy, done, stall_cnt); else passed++;
        tick();
        bus.ready = 0;
    endtask

    task automatic test_random();
        int stop_at, en_lo;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, $urandom_range(3), NI'($urandom_range(3)), NI*DW'($urandom));
            stop_at = ($urandom_range(1) == 1) ? int'($urandom_range(35, 5)) : -1;
            en_lo   = $urandom_range(30, 1);
            play($urandom_range(13), 1'($urandom_range(1)), 40, $urandom_range(100, 50),
                 -1, -1, stop_at, en_lo, en_lo + int'($urandom_range(3)), 1);
            end_play();
        end
    endtask

    initial begin
        rst = 1; en = 1; start = 0; stop = 0; loop_mode = 0; num_events = '0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_delta = '0; bus.wr_mask = '0; bus.wr_data = '0; bus.ready = 0;
        test_reset();
        test_basic_timing();
        test_multi_channel();
        test_backpressure();
        test_loop_and_stop();
        test_count_limits();
        test_enable();
        test_reset_mid_fire();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/trace_event_player.md
Name: trace_event_player

Overview:
Synthesizable, parametrised successor to the single-input hand-written stimulus sequence used for monitor end-to-end tests. It replays a preloaded table of timed events into a topEntity monitor over NUM_INPUTS channels, with multi-channel simultaneous events, back-pressure from the monitor queue, loop mode and abort. It sits between a host/loader and the monitor's input_k / new_input_k ports.

Parameters:
NUM_INPUTS, 1, number of monitor input streams
DATA_W, 64, width of each input value (signed, passed through unchanged)
DELTA_W, 32, width of the inter-event cycle delay field
DEPTH, 16, event table entries (power of two, >=2)
ADDR_W, $clog2(DEPTH), table address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable; 0 freezes all state
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write address
wr_delta  in  DELTA_W  idle cycles before this event
wr_mask  in  NUM_INPUTS  channels that fire in this event
wr_data  in  NUM_INPUTS*DATA_W  channel values, channel k at bits [k*DATA_W +: DATA_W]
num_events  in  ADDR_W+1  events to play, sampled at start
loop_mode  in  1  sampled at start; 1 = wrap to entry 0 after last
start  in  1  begin playback (IDLE/DONE only)
stop  in  1  abort playback
ready  in  1  monitor can accept an event (queue push valid)
input_flat  out  NUM_INPUTS*DATA_W  values to monitor input_k
new_input  out  NUM_INPUTS  per-channel one-cycle event strobe
busy  out  1  state is WAIT or FIRE
done  out  1  one-shot playback completed
event_idx  out  ADDR_W  entry currently pending
loop_cnt  out  16  completed passes in loop mode (saturating)
stall_cnt  out  32  cycles spent in FIRE with ready=0 (saturating)

Behaviour:
- All state updates only when en=1 (rst overrides en). When en=0: state, counters, table frozen; new_input and input_flat forced 0.
- Reset: state IDLE; new_input=0, input_flat=0, busy=0, done=0, event_idx=0, loop_cnt=0, stall_cnt=0, delay counter=0. Table contents not reset.
- Table writes: accepted in IDLE/DONE only; ignored while busy. Table read is combinational from event_idx.
- States: IDLE, WAIT, FIRE, DONE.
- IDLE/DONE + start: latch N=min(num_events,DEPTH), loop_mode; event_idx=0; stall_cnt, loop_cnt cleared; done=0. N=0 -> DONE directly. Else WAIT, counter loaded with entry delta.
- WAIT: counter==0 -> FIRE next cycle, else decrement. Start sampled in cycle T with delta d -> first FIRE cycle T+1+d.
- FIRE: if ready=1: new_input = entry mask, input_flat = entry data for masked channels, 0 for unmasked (combinational, same cycle); event consumed. If ready=0: outputs 0, stall_cnt+1, stay in FIRE.
- After consumption: event_idx==N-1 -> loop_mode ? (event_idx=0, loop_cnt+1, WAIT) : DONE, done=1. Else event_idx+1, WAIT with next delta. Delta d after pulse at cycle P -> next FIRE at P+1+d; d=0 gives back-to-back strobes.
- Mask 0 entry: consumed normally (pure delay), no strobe, ready ignored.
- Outside FIRE-with-ready: new_input=0, input_flat=0.
- stop: priority over everything except rst; in WAIT/FIRE -> IDLE next cycle, no strobe in stop cycle, done stays 0. In IDLE/DONE: DONE -> IDLE, done=0. start and stop together: stop wins.
- start while busy: ignored.
- done held until start, stop or rst.
- Saturating counters hold at all-ones.

Test Plan:
- NUM_INPUTS=1; entries {d=3,v=1},{d=0,v=2},{d=1,v=3}, N=3, start at cycle 10, ready=1 -> new_input at cycles 14, 15, 17 with input_flat 1,2,3; zero elsewhere; done=1 from cycle 18.
- NUM_INPUTS=2; entry mask=2'b11 data {7,-5} -> both strobes same cycle, input_flat ch0=7 ch1=-5; mask=2'b01 data {9,4} -> ch1 value output 0.
- ready low 4 cycles at due cycle -> no strobe for 4 cycles, stall_cnt=4, strobe on 5th; next event's delay counts from that cycle.
- loop_mode=1, N=2, d=0 each -> strobes every cycle, event_idx 0,1,0,1; loop_cnt=3 after 6 strobes; stop mid-WAIT -> IDLE, no further strobes, done=0.
- N=0 start -> DONE next cycle, no strobe; num_events=DEPTH+5 -> exactly DEPTH strobes.
- en=0 for 3 cycles during WAIT and during a FIRE cycle -> outputs 0, strobe deferred by exactly 3 cycles; rst mid-FIRE -> all outputs 0 next cycle, IDLE.
